// File: rtl/axis_frame_gate_pkg.sv
// ---------------------------------------------------------------------------
// axis_frame_gate_pkg
//   Shared types and constants for the AXI-Stream frame gate.
//   - state_t           : FSM state encoding (IDLE / FRAME / GAP), 2 bits.
//   - FRAME_COUNT_WIDTH : width of the completed-frame status counter.
// ---------------------------------------------------------------------------
package axis_frame_gate_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int FRAME_COUNT_WIDTH = 32;

endpackage : axis_frame_gate_pkg

// File: rtl/axis_frame_gate.sv
// ---------------------------------------------------------------------------
// axis_frame_gate
//   Cuts a free-running AXI-Stream source into frames of cfg_length beats,
//   flags the final beat with tlast, and optionally repeats frames with an
//   idle gap of cfg_gap cycles in between. The data path is a zero-latency,
//   storage-free passthrough that is only opened while in FRAME.
//
// Ports
//   aclk, aresetn           clock, synchronous active-low reset
//   cfg_enable              level; low blocks starts / ends continuous mode
//   cfg_continuous          1 = repeat frames, 0 = one frame per start
//   cfg_length              beats per frame (0 is illegal -> cfg_error)
//   cfg_gap                 idle cycles between frames
//   start                   single-cycle start strobe
//   S_AXIS_*                upstream slave stream (tready/tvalid/tdata)
//   M_AXIS_*                downstream master stream (tready/tvalid/tdata/tlast)
//   busy                    registered, high whenever the FSM is not IDLE
//   cfg_error               sticky zero-length flag, cleared by a good start
//   frame_count             completed frames, wraps at 2^32
// ---------------------------------------------------------------------------
module axis_frame_gate
  import axis_frame_gate_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int LENGTH_WIDTH     = 16,
  parameter int GAP_WIDTH        = 16
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          cfg_enable,
  input  logic                          cfg_continuous,
  input  logic [LENGTH_WIDTH-1:0]       cfg_length,
  input  logic [GAP_WIDTH-1:0]          cfg_gap,
  input  logic                          start,
  output logic                          S_AXIS_tready,
  input  logic                          S_AXIS_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0]   S_AXIS_tdata,
  input  logic                          M_AXIS_tready,
  output logic                          M_AXIS_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0]   M_AXIS_tdata,
  output logic                          M_AXIS_tlast,
  output logic                          busy,
  output logic                          cfg_error,
  output logic [FRAME_COUNT_WIDTH-1:0]  frame_count
);

  state_t                  state, state_next;

  logic [LENGTH_WIDTH-1:0] len_q;
  logic [GAP_WIDTH-1:0]    gap_q;
  logic                    cont_q;
  logic [LENGTH_WIDTH-1:0] beat_cnt;
  logic [GAP_WIDTH-1:0]    gap_timer;

  // Control strobes produced by the next-state logic for the datapath.
  logic latch_cfg;   // (re)load length/gap and zero the beat counter
  logic set_err;
  logic clr_err;
  logic load_gap;
  logic frame_done;

  logic handshake;
  logic last_beat;

  // In FRAME the downstream valid is the upstream valid, so a handshake is
  // simply upstream valid with downstream ready.
  assign handshake = (state == ST_FRAME) && S_AXIS_tvalid && M_AXIS_tready;
  assign last_beat = (beat_cnt == len_q - LENGTH_WIDTH'(1));

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    latch_cfg  = 1'b0;
    set_err    = 1'b0;
    clr_err    = 1'b0;
    load_gap   = 1'b0;
    frame_done = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start && cfg_enable) begin
          if (cfg_length != '0) begin
            state_next = ST_FRAME;
            latch_cfg  = 1'b1;
            clr_err    = 1'b1;
          end else begin
            set_err = 1'b1;
          end
        end
      end

      ST_FRAME: begin
        if (handshake && last_beat) begin
          frame_done = 1'b1;
          if (cont_q && cfg_enable) begin
            if (gap_q != '0) begin
              state_next = ST_GAP;
              load_gap   = 1'b1;
            end else begin
              // Back-to-back frame: re-latch config, refuse a zero length.
              latch_cfg = 1'b1;
              if (cfg_length != '0) begin
                state_next = ST_FRAME;
              end else begin
                state_next = ST_IDLE;
                set_err    = 1'b1;
              end
            end
          end else begin
            state_next = ST_IDLE;
          end
        end
      end

      ST_GAP: begin
        // Leaving on timer==1 makes the gap exactly gap_q idle cycles.
        if (gap_timer <= GAP_WIDTH'(1)) begin
          if (cfg_enable) begin
            latch_cfg = 1'b1;
            if (cfg_length != '0) begin
              state_next = ST_FRAME;
            end else begin
              state_next = ST_IDLE;
              set_err    = 1'b1;
            end
          end else begin
            state_next = ST_IDLE;
          end
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic: combinational passthrough, closed outside FRAME
  // -------------------------------------------------------------------------
  always_comb begin
    S_AXIS_tready = 1'b0;
    M_AXIS_tvalid = 1'b0;
    M_AXIS_tdata  = '0;
    M_AXIS_tlast  = 1'b0;
    if (state == ST_FRAME) begin
      S_AXIS_tready = M_AXIS_tready;
      M_AXIS_tvalid = S_AXIS_tvalid;
      M_AXIS_tdata  = S_AXIS_tdata;
      M_AXIS_tlast  = last_beat;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath: config latches, beat counter, gap timer, status registers
  // -------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      len_q       <= '0;
      gap_q       <= '0;
      cont_q      <= 1'b0;
      beat_cnt    <= '0;
      gap_timer   <= '0;
      cfg_error   <= 1'b0;
      frame_count <= '0;
      busy        <= 1'b0;
    end else begin
      if (latch_cfg) begin
        len_q    <= cfg_length;
        gap_q    <= cfg_gap;
        beat_cnt <= '0;
        // Mode is fixed for a run; only a fresh start from IDLE changes it.
        if (state == ST_IDLE) begin
          cont_q <= cfg_continuous;
        end
      end else if (handshake) begin
        beat_cnt <= beat_cnt + LENGTH_WIDTH'(1);
      end

      // The gap timer runs on time alone; downstream backpressure is ignored.
      if (load_gap) begin
        gap_timer <= gap_q;
      end else if (state == ST_GAP) begin
        gap_timer <= gap_timer - GAP_WIDTH'(1);
      end

      if (set_err) begin
        cfg_error <= 1'b1;
      end else if (clr_err) begin
        cfg_error <= 1'b0;
      end

      if (frame_done) begin
        frame_count <= frame_count + FRAME_COUNT_WIDTH'(1);
      end

      busy <= (state_next != ST_IDLE);
    end
  end

endmodule : axis_frame_gate
